// File: rtl/btm_share_arb.sv
// Two-requester round-robin front end sharing one pipelined truncated multiplier.
// Results return to the requester that issued them, exactly LAT cycles after acceptance.
module btm_share_arb #(
    parameter int BWOP = 10,
    parameter int NAB  = 0,
    parameter int LAT  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [BWOP-1:0] req0_a,
    input  logic [BWOP-1:0] req0_b,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [BWOP-1:0] req1_a,
    input  logic [BWOP-1:0] req1_b,
    output logic            req1_ready,
    output logic            rsp0_valid,
    output logic [BWOP-1:0] rsp0_c,
    output logic            rsp1_valid,
    output logic [BWOP-1:0] rsp1_c,
    output logic            busy,
    output logic [15:0]     ops_issued
);
    localparam int OPW = BWOP - NAB;
    localparam int RW  = BWOP - 2 * NAB;

    // last_grant = 1 means requester 1 won most recently, so requester 0 wins the next tie
    logic            last_grant;
    logic [LAT-1:0]  pipe_vld;
    logic [LAT-1:0]  pipe_id;
    logic [OPW-1:0]  pipe_a [LAT];
    logic [OPW-1:0]  pipe_b [LAT];
    logic [15:0]     issue_cnt;
    logic            grant0;
    logic            grant1;
    logic            accept;
    logic [OPW-1:0]  sel_a;
    logic [OPW-1:0]  sel_b;
    logic [RW-1:0]   prod_low;
    logic [BWOP-1:0] result;
    logic            out_vld;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign accept     = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sel_a = grant1 ? req1_a[BWOP-1:NAB] : req0_a[BWOP-1:NAB];
    assign sel_b = grant1 ? req1_b[BWOP-1:NAB] : req0_b[BWOP-1:NAB];

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            pipe_vld   <= '0;
            issue_cnt  <= '0;
        end else begin
            if (accept) begin
                last_grant <= grant1;
                issue_cnt  <= issue_cnt + 16'd1;
            end
            pipe_vld[0] <= accept;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    // Payload needs no reset: it is only observed when the matching valid bit is set
    always_ff @(posedge clk) begin
        pipe_id[0] <= grant1;
        pipe_a[0]  <= sel_a;
        pipe_b[0]  <= sel_b;
        for (int i = 1; i < LAT; i++) begin
            pipe_id[i] <= pipe_id[i-1];
            pipe_a[i]  <= pipe_a[i-1];
            pipe_b[i]  <= pipe_b[i-1];
        end
    end

    // Only the low RW product bits survive; the dropped LSB weight is restored by the shift
    assign prod_low = RW'(pipe_a[LAT-1] * pipe_b[LAT-1]);
    assign result   = BWOP'(prod_low) << (2 * NAB);

    assign out_vld    = !rst && pipe_vld[LAT-1];
    assign rsp0_valid = out_vld && !pipe_id[LAT-1];
    assign rsp1_valid = out_vld && pipe_id[LAT-1];
    assign rsp0_c     = rsp0_valid ? result : '0;
    assign rsp1_c     = rsp1_valid ? result : '0;
    assign busy       = !rst && (|pipe_vld);
    assign ops_issued = rst ? 16'd0 : issue_cnt;

endmodule

// File: tb/tb_btm_share_arb.sv
// Bench for btm_share_arb: NAB=0 and NAB=1 instances share stimulus and are checked
// every cycle against a queue-based model, plus directed literal checks.
module tb_btm_share_arb;
    localparam int BWOP = 10;
    localparam int LAT  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req1_valid;
    logic [BWOP-1:0] req0_a, req0_b, req1_a, req1_b;

    logic            n0_req0_ready, n0_req1_ready, n0_rsp0_valid, n0_rsp1_valid, n0_busy;
    logic [BWOP-1:0] n0_rsp0_c, n0_rsp1_c;
    logic [15:0]     n0_ops_issued;
    logic            n1_req0_ready, n1_req1_ready, n1_rsp0_valid, n1_rsp1_valid, n1_busy;
    logic [BWOP-1:0] n1_rsp0_c, n1_rsp1_c;
    logic [15:0]     n1_ops_issued;

    btm_share_arb #(.BWOP(BWOP), .NAB(0), .LAT(LAT)) dut_n0 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(n0_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(n0_req1_ready),
        .rsp0_valid(n0_rsp0_valid), .rsp0_c(n0_rsp0_c),
        .rsp1_valid(n0_rsp1_valid), .rsp1_c(n0_rsp1_c),
        .busy(n0_busy), .ops_issued(n0_ops_issued)
    );

    btm_share_arb #(.BWOP(BWOP), .NAB(1), .LAT(LAT)) dut_n1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(n1_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(n1_req1_ready),
        .rsp0_valid(n1_rsp0_valid), .rsp0_c(n1_rsp0_c),
        .rsp1_valid(n1_rsp1_valid), .rsp1_c(n1_rsp1_c),
        .busy(n1_busy), .ops_issued(n1_ops_issued)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;
    int cycle       = 0;

    typedef struct {
        int due;
        bit id;
        int c0;
        int c1;
    } rsp_t;

    rsp_t pending[$];
    rsp_t item;
    int   lastGrant = 1;
    int   opsModel  = 0;
    bit   expReady0, expReady1, expRsp0, expRsp1, expBusy;
    int   expC0n0, expC1n0, expC0n1, expC1n1, expOps;

    // Truncated product straight from the arithmetic definition
    function automatic int truncMul(int a, int b, int nab);
        int ap   = a >> nab;
        int bp   = b >> nab;
        int p    = ap * bp;
        int keep = BWOP - 2 * nab;
        return (p % (1 << keep)) * (1 << (2 * nab));
    endfunction

    task automatic checkOutput(string name, int actual, int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s @cycle %0d: got %0d, expected %0d", name, cycle, actual, expected);
        end
    endtask

    task automatic applyStimulus(bit r, bit v0, int a0, int b0, bit v1, int a1, int b1);
        @(posedge clk);
        #1;
        rst        = r;
        req0_valid = v0;
        req0_a     = BWOP'(a0);
        req0_b     = BWOP'(b0);
        req1_valid = v1;
        req1_a     = BWOP'(a1);
        req1_b     = BWOP'(b1);
    endtask

    task automatic idle(int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    // Per-cycle compare: derive expectations from the model, check both instances, then advance the model
    always @(negedge clk) begin
        expReady0 = 0; expReady1 = 0; expRsp0 = 0; expRsp1 = 0; expBusy = 0;
        expC0n0 = 0; expC1n0 = 0; expC0n1 = 0; expC1n1 = 0; expOps = 0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                expReady0 = (lastGrant == 1);
                expReady1 = (lastGrant == 0);
            end else begin
                expReady0 = req0_valid;
                expReady1 = req1_valid;
            end
            expBusy = (pending.size() > 0);
            expOps  = opsModel % 65536;
            if (pending.size() > 0 && pending[0].due == cycle) begin
                item = pending.pop_front();
                if (item.id) begin
                    expRsp1 = 1; expC1n0 = item.c0; expC1n1 = item.c1;
                end else begin
                    expRsp0 = 1; expC0n0 = item.c0; expC0n1 = item.c1;
                end
            end
        end
        checkOutput("n0_req0_ready", n0_req0_ready, expReady0);
        checkOutput("n0_req1_ready", n0_req1_ready, expReady1);
        checkOutput("n0_rsp0_valid", n0_rsp0_valid, expRsp0);
        checkOutput("n0_rsp1_valid", n0_rsp1_valid, expRsp1);
        checkOutput("n0_rsp0_c", n0_rsp0_c, expC0n0);
        checkOutput("n0_rsp1_c", n0_rsp1_c, expC1n0);
        checkOutput("n0_busy", n0_busy, expBusy);
        checkOutput("n0_ops_issued", n0_ops_issued, expOps);
        checkOutput("n1_req0_ready", n1_req0_ready, expReady0);
        checkOutput("n1_req1_ready", n1_req1_ready, expReady1);
        checkOutput("n1_rsp0_valid", n1_rsp0_valid, expRsp0);
        checkOutput("n1_rsp1_valid", n1_rsp1_valid, expRsp1);
        checkOutput("n1_rsp0_c", n1_rsp0_c, expC0n1);
        checkOutput("n1_rsp1_c", n1_rsp1_c, expC1n1);
        checkOutput("n1_busy", n1_busy, expBusy);
        checkOutput("n1_ops_issued", n1_ops_issued, expOps);

        if (rst) begin
            pending.delete();
            lastGrant = 1;
            opsModel  = 0;
        end else if (expReady0 || expReady1) begin
            item.due = cycle + LAT;
            item.id  = expReady1;
            item.c0  = expReady1 ? truncMul(req1_a, req1_b, 0) : truncMul(req0_a, req0_b, 0);
            item.c1  = expReady1 ? truncMul(req1_a, req1_b, 1) : truncMul(req0_a, req0_b, 1);
            pending.push_back(item);
            lastGrant = expReady1 ? 1 : 0;
            opsModel++;
        end
        cycle++;
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

        // Reset state, with both valids high to show ready stays low
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req0_ready", n0_req0_ready, 0);
        checkOutput("reset_req1_ready", n0_req1_ready, 0);
        checkOutput("reset_busy", n0_busy, 0);
        checkOutput("reset_ops", n0_ops_issued, 0);

        // Single request 3*5
        applyStimulus(1'b0, 1'b1, 3, 5, 1'b0, 0, 0);
        @(negedge clk);
        checkOutput("first_grant_req0", n0_req0_ready, 1);
        idle(2);
        @(negedge clk);
        checkOutput("mul3x5_valid", n0_rsp0_valid, 1);
        checkOutput("mul3x5_c", n0_rsp0_c, 15);
        checkOutput("mul3x5_rsp1_quiet", n0_rsp1_valid, 0);

        // Overflow discard on requester 1
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 1023, 2);
        idle(2);
        @(negedge clk);
        checkOutput("ovf_valid", n0_rsp1_valid, 1);
        checkOutput("ovf_c", n0_rsp1_c, 1022);

        // Truncated operands: 7*5 becomes 3*2 scaled by 4 when NAB=1
        applyStimulus(1'b0, 1'b1, 7, 5, 1'b0, 0, 0);
        idle(2);
        @(negedge clk);
        checkOutput("nab1_c", n1_rsp0_c, 24);
        checkOutput("nab0_c", n0_rsp0_c, 35);

        // Two ops in flight, reset before they emerge
        applyStimulus(1'b0, 1'b1, 11, 13, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 17, 19);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
        @(negedge clk);
        checkOutput("flush_rsp0_in_reset", n0_rsp0_valid, 0);
        idle(1);
        @(negedge clk);
        checkOutput("flush_rsp1", n0_rsp1_valid, 0);
        checkOutput("flush_busy", n0_busy, 0);
        checkOutput("flush_ops", n0_ops_issued, 0);
        idle(1);
        @(negedge clk);
        checkOutput("flush_rsp0_late", n0_rsp0_valid, 0);

        // Contention right after reset: grants alternate starting with requester 0
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 20 + k, 3, 1'b1, 40 + k, 2);
            @(negedge clk);
            checkOutput("alt_grant0", n0_req0_ready, (k % 2 == 0) ? 1 : 0);
            if (k == 2) checkOutput("alt_rsp0_t2", n0_rsp0_valid, 1);
            if (k == 3) checkOutput("alt_rsp1_t3", n0_rsp1_valid, 1);
        end
        idle(3);

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          1'($urandom_range(0, 1)), $urandom_range(0, 1023), $urandom_range(0, 1023),
                          1'($urandom_range(0, 1)), $urandom_range(0, 1023), $urandom_range(0, 1023));
        end
        idle(3);

        // Counter wrap: 65535 acceptances, then one more
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
        for (int n = 0; n < 65535; n++) begin
            applyStimulus(1'b0, 1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023),
                          1'($urandom_range(0, 1)), $urandom_range(0, 1023), $urandom_range(0, 1023));
        end
        idle(1);
        @(negedge clk);
        checkOutput("ops_full", n0_ops_issued, 65535);
        applyStimulus(1'b0, 1'b1, 9, 9, 1'b0, 0, 0);
        idle(1);
        @(negedge clk);
        checkOutput("ops_wrap", n0_ops_issued, 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/btm_share_arb.md
BTM_SHARE_ARB -- requirements
Module: btm_share_arb

Interface
REQ-001 The block SHALL have parameter BWOP, default 10, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter NAB, default 0, giving the number of truncated LSBs per operand; legal range is 0 <= 2*NAB < BWOP.
REQ-003 The block SHALL have parameter LAT, default 2, giving the multiplier pipeline depth in cycles; legal range is LAT >= 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester N presents an operation.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, BWOP bits each: the operands of each requester.
REQ-008 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: operation accepted this cycle.
REQ-009 The block SHALL have ports rsp0_valid and rsp1_valid, output, 1 bit each: one-cycle result pulse for requester N.
REQ-010 The block SHALL have ports rsp0_c and rsp1_c, output, BWOP bits each: the result for requester N.
REQ-011 The block SHALL have port busy, output, 1 bit: at least one operation is in flight.
REQ-012 The block SHALL have port ops_issued, output, 16 bits: count of accepted operations, wrapping.

Function
REQ-013 The block SHALL share one truncated multiplier between requester 0 and requester 1 and SHALL accept at most one operation per cycle.
REQ-014 An operation SHALL be accepted in a cycle where reqN_valid=1 and reqN_ready=1; reqN_ready SHALL be combinational from both valids and the round-robin pointer.
REQ-015 Arbitration, only one valid: that requester SHALL be granted.
REQ-016 Arbitration, both valid: the requester not granted most recently SHALL be granted.
REQ-017 Arbitration, round-robin pointer: the pointer SHALL update only on acceptance.
REQ-018 Arbitration, neither valid: both reqN_ready SHALL be 0.
REQ-019 Arbitration, fairness: req0_ready and req1_ready SHALL never both be 1 in the same cycle.
REQ-020 Arithmetic, operand truncation: the effective operands SHALL be a' = a[BWOP-1:NAB] and b' = b[BWOP-1:NAB], and p = a' * b' at full width.
REQ-021 Arithmetic, NAB=0: c SHALL be p[BWOP-1:0].
REQ-022 Arithmetic, NAB>0: c SHALL be {p[BWOP-2*NAB-1:0], 2*NAB zero bits}.
REQ-023 Arithmetic, overflow: bits of p above the retained field SHALL be discarded silently.
REQ-024 Pipeline: operands, a valid flag and a 1-bit requester ID SHALL advance one stage per cycle through LAT stages, with no stall and no backpressure.
REQ-025 An operation accepted in cycle t SHALL produce rspN_valid=1 with rspN_c in cycle t+LAT, where N is the ID captured at acceptance.
REQ-026 rsp0_valid and rsp1_valid SHALL never both be 1 in the same cycle.
REQ-027 rspN_c SHALL be 0 whenever rspN_valid=0.
REQ-028 busy SHALL be the OR of all pipeline valid flags, combinational, and SHALL be 0 when the pipeline is empty.
REQ-029 ops_issued SHALL increment by 1 on each acceptance and SHALL wrap from 65535 to 0.
REQ-030 Back-to-back acceptances SHALL be sustained indefinitely at a throughput of 1 operation per cycle.

Reset
REQ-031 While rst=1, all pipeline valid flags SHALL clear.
REQ-032 While rst=1, ops_issued SHALL be 0.
REQ-033 While rst=1, the round-robin pointer SHALL be set so that requester 0 wins the first contended cycle.
REQ-034 While rst=1, all outputs SHALL be 0, including req0_ready and req1_ready.
REQ-035 Operations in flight when rst asserts SHALL be discarded and SHALL produce no rspN_valid pulse after rst deasserts.
REQ-036 After rst deasserts, the first acceptance SHALL be possible in the next cycle.

Verification (BWOP=10, LAT=2 unless stated)
REQ-037 NAB=0: req0 a=3, b=5 accepted at cycle t -> rsp0_valid=1, rsp0_c=15 at t+2; rsp1_valid=0 throughout.
REQ-038 NAB=0: req0 and req1 held valid from cycle t -> grants alternate 0,1,0,1; responses alternate at t+2, t+3, ...; ops_issued increments each cycle.
REQ-039 NAB=0: req1 a=1023, b=2 -> rsp1_c=1022 (overflow discarded).
REQ-040 NAB=1: req0 a=7, b=5 -> a'=3, b'=2, p=6 -> rsp0_c=24.
REQ-041 Accept 2 operations, then assert rst for 1 cycle before results emerge -> no rsp pulses; busy=0 and ops_issued=0 after reset.
REQ-042 Force ops_issued to 65535 by 65535 acceptances, then accept one more -> ops_issued=0.
